// File: rtl/padlock_code_sender.sv
// padlock_code_sender: plays a 4-digit, 2-bit-per-digit code onto the padlock's buttons as
// 1-cycle pulses, pulses open, then reports ~lock. Optional macro: PADLOCK_SENDER_ALIGN_EN.
module padlock_code_sender #(
  parameter int GAP = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] code,
  input  logic       lock,
  output logic       but_0,
  output logic       but_1,
  output logic       but_2,
  output logic       but_3,
  output logic       open,
  output logic       busy,
  output logic       done,
  output logic       success,
  output logic [2:0] o_dbg_state
);
  // Handshake: start is taken only while the FSM is IDLE (busy=0 and not the done
  // cycle); busy rises the cycle after an accepted start and falls in the done cycle.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
`ifdef PADLOCK_SENDER_ALIGN_EN
    S_ALIGN = 3'd1,
`endif
    S_PRESS = 3'd2,
    S_GAP   = 3'd3,
    S_OPEN  = 3'd4,
    S_CHECK = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [7:0] GAP_LAST = 8'((GAP > 0) ? (GAP - 1) : 0);
  localparam bit         GAP_ZERO = (GAP == 0);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_code, w_code_nxt;
  logic [2:0] r_idx, w_idx_nxt;
  logic [7:0] r_gap_cnt, w_gap_cnt_nxt;
  logic [3:0] r_but, w_but_nxt;
  logic       r_open, w_open_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_done, w_done_nxt;
  logic       r_success, w_success_nxt;
  logic [1:0] w_digit;
`ifdef PADLOCK_SENDER_ALIGN_EN
  logic [1:0] r_sent_cnt, w_sent_cnt_nxt;
  logic [1:0] r_fill, w_fill_nxt;
`endif

  function automatic state_t seq_state(input logic [2:0] idx);
    return (idx < 3'd4) ? S_PRESS : S_OPEN;
  endfunction

  always_comb begin
    w_state_nxt   = r_state;
    w_code_nxt    = r_code;
    w_idx_nxt     = r_idx;
    w_gap_cnt_nxt = r_gap_cnt;
`ifdef PADLOCK_SENDER_ALIGN_EN
    w_fill_nxt    = r_fill;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_code_nxt = code;
          w_idx_nxt  = 3'd0;
`ifdef PADLOCK_SENDER_ALIGN_EN
          // Fillers bring the padlock write index back to slot 0 before digit 0.
          w_fill_nxt  = 2'd0 - r_sent_cnt;
          w_state_nxt = (w_fill_nxt != 2'd0) ? S_ALIGN : S_PRESS;
`else
          w_state_nxt = S_PRESS;
`endif
        end
      end
`ifdef PADLOCK_SENDER_ALIGN_EN
      S_ALIGN: begin
        w_fill_nxt    = r_fill - 2'd1;
        w_gap_cnt_nxt = '0;
        if (!GAP_ZERO) w_state_nxt = S_GAP;
        else           w_state_nxt = (w_fill_nxt != 2'd0) ? S_ALIGN : S_PRESS;
      end
`endif
      S_PRESS: begin
        w_idx_nxt     = r_idx + 3'd1;
        w_gap_cnt_nxt = '0;
        w_state_nxt   = GAP_ZERO ? seq_state(w_idx_nxt) : S_GAP;
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
`ifdef PADLOCK_SENDER_ALIGN_EN
          w_state_nxt = (r_fill != 2'd0) ? S_ALIGN : seq_state(r_idx);
`else
          w_state_nxt = seq_state(r_idx);
`endif
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + 8'd1;
        end
      end
      S_OPEN:  w_state_nxt = S_CHECK;
      S_CHECK: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Outputs are decoded from the next state so every output comes straight from a flop.
    w_digit   = w_code_nxt[{w_idx_nxt[1:0], 1'b0} +: 2];
    w_but_nxt = '0;
    if (w_state_nxt == S_PRESS) w_but_nxt[w_digit] = 1'b1;
`ifdef PADLOCK_SENDER_ALIGN_EN
    if (w_state_nxt == S_ALIGN) w_but_nxt[0] = 1'b1;
    w_sent_cnt_nxt = r_sent_cnt + {1'b0, |w_but_nxt};
`endif
    w_open_nxt    = (w_state_nxt == S_OPEN);
    w_done_nxt    = (w_state_nxt == S_DONE);
    w_busy_nxt    = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
    w_success_nxt = r_success;
    if (w_state_nxt == S_DONE)           w_success_nxt = ~lock;
    else if (r_state == S_IDLE && start) w_success_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_code     <= '0;
      r_idx      <= '0;
      r_gap_cnt  <= '0;
      r_but      <= '0;
      r_open     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_success  <= 1'b0;
`ifdef PADLOCK_SENDER_ALIGN_EN
      r_sent_cnt <= '0;
      r_fill     <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_code     <= w_code_nxt;
      r_idx      <= w_idx_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
      r_but      <= w_but_nxt;
      r_open     <= w_open_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_success  <= w_success_nxt;
`ifdef PADLOCK_SENDER_ALIGN_EN
      r_sent_cnt <= w_sent_cnt_nxt;
      r_fill     <= w_fill_nxt;
`endif
    end
  end

  assign but_0       = r_but[0];
  assign but_1       = r_but[1];
  assign but_2       = r_but[2];
  assign but_3       = r_but[3];
  assign open        = r_open;
  assign busy        = r_busy;
  assign done        = r_done;
  assign success     = r_success;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_padlock_code_sender.sv
// Bench for padlock_code_sender: a GAP=2 instance driving a behavioural padlock and a GAP=0
// instance with lock held high; event scoreboards keyed by cycle number.
module tb_padlock_code_sender;
  localparam logic [7:0] SECRET = 8'h36;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, start0 = 1'b0;
  logic [7:0] code = 8'h00, code0 = 8'h00;
  logic       lock, lock0, lock_force = 1'b0;
  logic       p_b0, p_b1, p_b2, p_b3, p_open, p_busy, p_done, p_success;
  logic       q_b0, q_b1, q_b2, q_b3, q_open, q_busy, q_done, q_success;
  logic [2:0] p_dbg, q_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [19:0] exp_q[$];
  logic [19:0] exp0_q[$];
  bit busy_map[2048];
  bit busy0_map[2048];

  // clock / reset / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  padlock_code_sender #(.GAP(2)) dut (
    .clk(clk), .reset(reset), .start(start), .code(code), .lock(lock),
    .but_0(p_b0), .but_1(p_b1), .but_2(p_b2), .but_3(p_b3), .open(p_open),
    .busy(p_busy), .done(p_done), .success(p_success), .o_dbg_state(p_dbg)
  );

  padlock_code_sender #(.GAP(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .code(code0), .lock(lock0),
    .but_0(q_b0), .but_1(q_b1), .but_2(q_b2), .but_3(q_b3), .open(q_open),
    .busy(q_busy), .done(q_done), .success(q_success), .o_dbg_state(q_dbg)
  );

  assign lock0 = 1'b1;

  // Behavioural 4-button padlock: presses fill slots in order, open compares, lock registered.
  logic [7:0] pl_slots;
  logic [1:0] pl_idx;
  logic       pl_lock;
  always @(posedge clk) begin
    if (reset) begin
      pl_slots <= 8'h00;
      pl_idx   <= 2'd0;
      pl_lock  <= 1'b1;
    end else begin
      if (p_b0 | p_b1 | p_b2 | p_b3) begin
        pl_slots[{pl_idx, 1'b0} +: 2] <= {p_b3 | p_b2, p_b3 | p_b1};
        pl_idx <= pl_idx + 2'd1;
      end
      if (p_open) pl_lock <= (pl_slots != SECRET);
    end
  end
  assign lock = lock_force | pl_lock;

  function automatic logic [2:0] kind_of(input logic b1, input logic b2, input logic b3,
                                         input logic op, input logic dn);
    if (b1) return 3'd1;
    if (b2) return 3'd2;
    if (b3) return 3'd3;
    if (op) return 3'd4;
    if (dn) return 3'd5;
    return 3'd0;
  endfunction

  // Expected events for a start held high in cycle s: {cycle, kind, success-at-done}.
  task automatic push_send(input bit which, input int s, input logic [7:0] c,
                           input int gap, input bit succ);
    int t;
    logic [19:0] item;
    for (int k = 0; k < 4; k++) begin
      t = s + 1 + k * (gap + 1);
      item = {16'(t), 1'b0, c[2*k +: 2], 1'b0};
      if (which) exp0_q.push_back(item); else exp_q.push_back(item);
    end
    t = s + 1 + 4 * (gap + 1);
    item = {16'(t), 3'd4, 1'b0};
    if (which) exp0_q.push_back(item); else exp_q.push_back(item);
    item = {16'(t + 2), 3'd5, succ};
    if (which) exp0_q.push_back(item); else exp_q.push_back(item);
    for (int b = s + 1; b <= t + 1; b++) begin
      if (which) busy0_map[b % 2048] = 1'b1; else busy_map[b % 2048] = 1'b1;
    end
  endtask

  // scoreboard monitor, GAP=2 instance
  always @(negedge clk) begin : mon_p
    logic [19:0] obs, e;
    if (!reset) begin
      checks++;
      if ($countones({p_b0, p_b1, p_b2, p_b3, p_open}) > 1) begin
        errors++;
        $display("FAIL onehot_p cyc=%0d pulses=%b required at most one", cyc,
                 {p_b3, p_b2, p_b1, p_b0, p_open});
      end
      checks++;
      if (p_busy !== busy_map[cyc % 2048]) begin
        errors++;
        $display("FAIL busy_p cyc=%0d got=%b exp=%b", cyc, p_busy, busy_map[cyc % 2048]);
      end
      if (p_b0 | p_b1 | p_b2 | p_b3 | p_open | p_done) begin
        obs = {16'(cyc), kind_of(p_b1, p_b2, p_b3, p_open, p_done), p_done & p_success};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL event_p unexpected cyc=%0d kind=%0d", cyc, obs[3:1]);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            errors++;
            $display("FAIL event_p got cyc=%0d kind=%0d succ=%0d exp cyc=%0d kind=%0d succ=%0d",
                     obs[19:4], obs[3:1], obs[0], e[19:4], e[3:1], e[0]);
          end
        end
      end
    end
  end

  // scoreboard monitor, GAP=0 instance
  always @(negedge clk) begin : mon_q
    logic [19:0] obs, e;
    if (!reset) begin
      checks++;
      if ($countones({q_b0, q_b1, q_b2, q_b3, q_open}) > 1) begin
        errors++;
        $display("FAIL onehot_q cyc=%0d pulses=%b required at most one", cyc,
                 {q_b3, q_b2, q_b1, q_b0, q_open});
      end
      checks++;
      if (q_busy !== busy0_map[cyc % 2048]) begin
        errors++;
        $display("FAIL busy_q cyc=%0d got=%b exp=%b", cyc, q_busy, busy0_map[cyc % 2048]);
      end
      if (q_b0 | q_b1 | q_b2 | q_b3 | q_open | q_done) begin
        obs = {16'(cyc), kind_of(q_b1, q_b2, q_b3, q_open, q_done), q_done & q_success};
        checks++;
        if (exp0_q.size() == 0) begin
          errors++;
          $display("FAIL event_q unexpected cyc=%0d kind=%0d", cyc, obs[3:1]);
        end else begin
          e = exp0_q.pop_front();
          if (obs !== e) begin
            errors++;
            $display("FAIL event_q got cyc=%0d kind=%0d succ=%0d exp cyc=%0d kind=%0d succ=%0d",
                     obs[19:4], obs[3:1], obs[0], e[19:4], e[3:1], e[0]);
          end
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({p_b3, p_b2, p_b1, p_b0, p_open, p_busy, p_done, p_success} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outs_p got=%b exp=00000000",
               {p_b3, p_b2, p_b1, p_b0, p_open, p_busy, p_done, p_success});
    end
    checks++;
    if (p_dbg !== 3'd0) begin
      errors++;
      $display("FAIL reset_state_p got=%0d exp=0", p_dbg);
    end
    checks++;
    if ({q_b3, q_b2, q_b1, q_b0, q_open, q_busy, q_done, q_success} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outs_q got=%b exp=00000000",
               {q_b3, q_b2, q_b1, q_b0, q_open, q_busy, q_done, q_success});
    end
    checks++;
    if (q_dbg !== 3'd0) begin
      errors++;
      $display("FAIL reset_state_q got=%0d exp=0", q_dbg);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_send(input logic [7:0] c, input bit force_lock);
    int s;
    bit succ;
    @(negedge clk);
    lock_force = force_lock;
    start = 1'b1;
    code  = c;
    s     = cyc;
    succ  = !force_lock && (c == SECRET);
    push_send(1'b0, s, c, 2, succ);
    @(negedge clk);
    start = 1'b0;
    code  = 8'($urandom_range(0, 255));
    repeat (20) @(negedge clk);
    checks++;
    if (p_success !== succ) begin
      errors++;
      $display("FAIL success_hold code=%h got=%b exp=%b", c, p_success, succ);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_p code=%h got=%0d left exp=0", c, exp_q.size());
      exp_q.delete();
    end
    lock_force = 1'b0;
  endtask

  task automatic test_gap0();
    int s;
    @(negedge clk);
    start0 = 1'b1;
    code0  = SECRET;
    s      = cyc;
    push_send(1'b1, s, SECRET, 0, 1'b0);
    @(negedge clk);
    start0 = 1'b0;
    code0  = 8'($urandom_range(0, 255));
    repeat (10) @(negedge clk);
    checks++;
    if (exp0_q.size() != 0) begin
      errors++;
      $display("FAIL pending_q got=%0d left exp=0", exp0_q.size());
      exp0_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    int s;
    @(negedge clk);
    start = 1'b1;
    code  = SECRET;
    s     = cyc;
    push_send(1'b0, s, SECRET, 2, 1'b1);
    push_send(1'b0, s + 16, 8'h00, 2, 1'b0);
    @(negedge clk);
    code = 8'h00;
    repeat (16) @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    checks++;
    if (p_success !== 1'b0) begin
      errors++;
      $display("FAIL b2b_success got=%b exp=0", p_success);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_pending got=%0d left exp=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    int s;
    @(negedge clk);
    start = 1'b1;
    code  = SECRET;
    s     = cyc;
    push_send(1'b0, s, SECRET, 2, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    for (int b = s + 7; b < s + 20; b++) busy_map[b % 2048] = 1'b0;
    @(negedge clk);
    checks++;
    if ({p_b3, p_b2, p_b1, p_b0, p_open, p_busy, p_done, p_success} !== 8'h00) begin
      errors++;
      $display("FAIL midreset_outs got=%b exp=00000000",
               {p_b3, p_b2, p_b1, p_b0, p_open, p_busy, p_done, p_success});
    end
    checks++;
    if (p_dbg !== 3'd0) begin
      errors++;
      $display("FAIL midreset_state got=%0d exp=0", p_dbg);
    end
    reset = 1'b0;
    repeat (8) @(negedge clk);
  endtask

`ifdef PADLOCK_SENDER_ALIGN_EN
  task automatic test_align();
    test_send(8'h00, 1'b1);
    test_send(SECRET, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_send(SECRET, 1'b0);
    test_send(8'h00, 1'b0);
    test_gap0();
    test_back_to_back();
    test_reset_mid();
    test_send(SECRET, 1'b0);
    test_send(8'h9C, 1'b0);
`ifdef PADLOCK_SENDER_ALIGN_EN
    test_align();
`endif
    checks++;
    if (exp_q.size() != 0 || exp0_q.size() != 0) begin
      errors++;
      $display("FAIL final_pending got=%0d/%0d exp=0/0", exp_q.size(), exp0_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
